// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the two-master data-memory arbiter:
//   arb_state_t  - ownership state (who was granted in the previous cycle)
//   DEF_DATA_W   - default memory word width
//   DEF_ADDR_W   - default byte address width
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner selection for the data-memory arbiter.
// Ports:
//   i_req0, i_req1 - requests from m0 / m1
//   i_state        - requester granted in the previous cycle
//   i_hold         - consecutive grants given to the current owner
//   i_rr           - tie winner when idle (0 = m0, 1 = m1)
//   o_gnt0, o_gnt1 - one-hot (or zero) grant
// ---------------------------------------------------------------------------
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int HOLD_W   = $clog2(HOLD_MAX + 1)
) (
   input  logic              i_req0,
   input  logic              i_req1,
   input  arb_state_t        i_state,
   input  logic [HOLD_W-1:0] i_hold,
   input  logic              i_rr,
   output logic              o_gnt0,
   output logic              o_gnt1
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

   logic w_hold_done;
   logic w_pick1;

   assign w_hold_done = (i_hold >= HOLD_LIM);

   // Only consulted when both masters request; a lone requester always wins.
   always_comb begin
      w_pick1 = 1'b0;
      case (i_state)
         ST_OWN0: w_pick1 = w_hold_done;
         ST_OWN1: w_pick1 = !w_hold_done;
         default: w_pick1 = i_rr;
      endcase
   end

   always_comb begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
      if (i_req0 && i_req1) begin
         o_gnt0 = !w_pick1;
         o_gnt1 = w_pick1;
      end else begin
         o_gnt0 = i_req0;
         o_gnt1 = i_req1;
      end
   end

endmodule : dmem_arb_pick

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-ported data memory between the CPU data port (m0) and
// a loader/debug port (m1). One access per cycle; read data is registered and
// returned to the requester one cycle after its grant.
// Ports:
//   clk, reset (synchronous, active low)
//   m*_req/we/addr/wdata  - master requests
//   m*_gnt                - access performed this cycle (combinational)
//   m*_rvalid/rdata       - registered read return
//   mem_access_addr, mem_write_data, mem_write_en, mem_read - memory request
//   mem_read_data         - combinational memory read data
// Build option: define DMEM_ARB_RR_EN to break idle ties round-robin;
// otherwise idle ties always go to m0.
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int HOLD_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_we,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int HOLD_W = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

   arb_state_t        r_state;
   arb_state_t        w_state_next;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_next;
   logic              w_pick0;
   logic              w_pick1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_rr;
   logic              r_m0_rvalid;
   logic              r_m1_rvalid;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   dmem_arb_pick #(
      .HOLD_MAX (HOLD_MAX),
      .HOLD_W   (HOLD_W)
   ) u_pick (
      .i_req0  (m0_req),
      .i_req1  (m1_req),
      .i_state (r_state),
      .i_hold  (r_hold),
      .i_rr    (w_rr),
      .o_gnt0  (w_pick0),
      .o_gnt1  (w_pick1)
   );

   // Grants are blocked while reset is held so no memory strobe escapes.
   assign w_gnt0 = w_pick0 & reset;
   assign w_gnt1 = w_pick1 & reset;
   assign m0_gnt = w_gnt0;
   assign m1_gnt = w_gnt1;

`ifdef DMEM_ARB_RR_EN
   // Points at the requester that wins the next idle tie.
   logic r_rr;
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rr <= 1'b0;
      end else if (w_gnt0) begin
         r_rr <= 1'b1;
      end else if (w_gnt1) begin
         r_rr <= 1'b0;
      end
   end
   assign w_rr = r_rr;
`else
   assign w_rr = 1'b0;
`endif

   always_comb begin
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      if (w_gnt0) begin
         mem_access_addr = m0_addr;
         mem_write_data  = m0_wdata;
         mem_write_en    = m0_we;
         mem_read        = !m0_we;
      end else if (w_gnt1) begin
         mem_access_addr = m1_addr;
         mem_write_data  = m1_wdata;
         mem_write_en    = m1_we;
         mem_read        = !m1_we;
      end
   end

   // Next ownership and hold count: a repeat grant to the same owner extends
   // the run (saturating), a new owner restarts at 1, no grant clears it.
   always_comb begin
      w_state_next = ST_IDLE;
      w_hold_next  = '0;
      if (w_gnt0) begin
         w_state_next = ST_OWN0;
         if (r_state == ST_OWN0) begin
            w_hold_next = (r_hold == HOLD_LIM) ? r_hold : r_hold + 1'b1;
         end else begin
            w_hold_next = HOLD_W'(1);
         end
      end else if (w_gnt1) begin
         w_state_next = ST_OWN1;
         if (r_state == ST_OWN1) begin
            w_hold_next = (r_hold == HOLD_LIM) ? r_hold : r_hold + 1'b1;
         end else begin
            w_hold_next = HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_hold      <= '0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_hold      <= w_hold_next;
         r_m0_rvalid <= w_gnt0 & !m0_we;
         r_m1_rvalid <= w_gnt1 & !m1_we;
         if (w_gnt0 && !m0_we) begin
            r_m0_rdata <= mem_read_data;
         end
         if (w_gnt1 && !m1_we) begin
            r_m1_rdata <= mem_read_data;
         end
      end
   end

   // A read returning while reset is being asserted is dropped immediately.
   assign m0_rvalid = r_m0_rvalid & reset;
   assign m1_rvalid = r_m1_rvalid & reset;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed and randomized stimulus for dmem_arbiter, checked every cycle
// against a transaction-level model of the arbitration rules and memory.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int HOLD = 4;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR_ON = 1'b1;
`else
   localparam bit RR_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m1_req, m0_we, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mem_access_addr;
   logic [DW-1:0] mem_write_data;
   logic          mem_write_en, mem_read;
   logic [DW-1:0] mem_read_data;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .HOLD_MAX(HOLD)) dut (
      .clk             (clk),
      .reset           (reset),
      .m0_req          (m0_req),
      .m1_req          (m1_req),
      .m0_we           (m0_we),
      .m1_we           (m1_we),
      .m0_addr         (m0_addr),
      .m1_addr         (m1_addr),
      .m0_wdata        (m0_wdata),
      .m1_wdata        (m1_wdata),
      .m0_gnt          (m0_gnt),
      .m1_gnt          (m1_gnt),
      .m0_rvalid       (m0_rvalid),
      .m1_rvalid       (m1_rvalid),
      .m0_rdata        (m0_rdata),
      .m1_rdata        (m1_rdata),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory attached to the DUT (256 words, low address byte indexes).
   logic [DW-1:0] dmem [0:255];
   assign mem_read_data = dmem[mem_access_addr[7:0]];
   always @(posedge clk) begin
      if (mem_write_en) dmem[mem_access_addr[7:0]] <= mem_write_data;
   end

   // Reference model state.
   logic [DW-1:0] mmem [0:255];
   int            m_owner;   // -1 none, 0 m0, 1 m1 (granted last cycle)
   int            m_run;     // consecutive grants to m_owner
   int            m_rr;      // idle tie winner
   logic          m_rv0, m_rv1;
   logic [DW-1:0] m_rd0, m_rd1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check against model, advance model.
   task automatic step(input logic rst,
                       input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      int            win;
      logic          eg0, eg1, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(posedge clk);
      #1;
      reset = rst;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      #3;
      win = -1;
      if (rst) begin
         if (r0 && r1) begin
            if (m_owner >= 0) win = (m_run < HOLD) ? m_owner : 1 - m_owner;
            else              win = RR_ON ? m_rr : 0;
         end else if (r0) win = 0;
         else if (r1)     win = 1;
      end
      eg0 = (win == 0);
      eg1 = (win == 1);
      ewe = eg0 ? w0 : (eg1 ? w1 : 1'b0);
      ea  = eg0 ? a0 : (eg1 ? a1 : '0);
      ed  = eg0 ? d0 : (eg1 ? d1 : '0);
      $display("t=%0t rst=%0b req=%0b%0b we=%0b%0b gnt=%0b%0b rv=%0b%0b rd0=%h rd1=%h",
               $time, rst, r0, r1, w0, w1, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
      check("m0_gnt", 32'(m0_gnt), 32'(eg0));
      check("m1_gnt", 32'(m1_gnt), 32'(eg1));
      check("mem_write_en", 32'(mem_write_en), 32'(ewe));
      check("mem_read", 32'(mem_read), 32'((eg0 || eg1) && !ewe));
      check("mem_access_addr", 32'(mem_access_addr), 32'(ea));
      check("mem_write_data", 32'(mem_write_data), 32'(ed));
      check("m0_rvalid", 32'(m0_rvalid), 32'(m_rv0 & rst));
      check("m1_rvalid", 32'(m1_rvalid), 32'(m_rv1 & rst));
      check("m0_rdata", 32'(m0_rdata), 32'(m_rd0));
      check("m1_rdata", 32'(m1_rdata), 32'(m_rd1));
      // Advance model to the state after the coming edge.
      if (!rst) begin
         m_owner = -1; m_run = 0; m_rr = 0;
         m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      end else begin
         m_rv0 = eg0 && !w0;
         m_rv1 = eg1 && !w1;
         if (m_rv0) m_rd0 = mmem[a0[7:0]];
         if (m_rv1) m_rd1 = mmem[a1[7:0]];
         if (win >= 0) begin
            m_run   = (m_owner == win) ? m_run + 1 : 1;
            m_owner = win;
            m_rr    = 1 - win;
            if (ewe) mmem[ea[7:0]] = ed;
         end else begin
            m_owner = -1; m_run = 0;
         end
      end
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      reset = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      for (int i = 0; i < 256; i++) begin
         dmem[i] = 16'(i * 16'h0101 + 16'h3C5A);
         mmem[i] = 16'(i * 16'h0101 + 16'h3C5A);
      end
      m_owner = -1; m_run = 0; m_rr = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;

      // Reset held with both masters requesting: nothing granted.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0008, '0);
      // Release: first grant to m0.
      step(1'b1, 1'b1, 1'b0, 16'h0004, '0, 1'b1, 1'b0, 16'h0008, '0);
      check("first_gnt_m0", 32'(m0_gnt), 32'd1);
      idle();
      idle();

      // m0 writes 0xBEEF to 0x0010, m1 reads it back.
      step(1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
      idle();
      check("m1_rvalid_beef", 32'(m1_rvalid), 32'd1);
      check("m1_rdata_beef", 32'(m1_rdata), 32'h0000BEEF);
      idle();

      // Both requesting continuously: hold-limited alternation.
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b1, 1'b0, 16'(i), '0, 1'b1, 1'b0, 16'(i + 32), '0);
      idle();

      // m1 alone for 10 cycles, then contention: m0 must win at once.
      for (int i = 0; i < 10; i++)
         step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'(i + 64), '0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b0, 16'(i + 80), '0, 1'b1, 1'b0, 16'(i + 96), '0);
      idle();

      // Idle tie after an m0 grant.
      step(1'b1, 1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0, '0, '0);
      idle();
      step(1'b1, 1'b1, 1'b0, 16'h0021, '0, 1'b1, 1'b0, 16'h0022, '0);
      check("idle_tie_m1_gnt", 32'(m1_gnt), 32'(RR_ON));
      idle();

      // Reset in the cycle after a granted read: rvalid suppressed, rdata 0.
      step(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      check("rst_rvalid_suppressed", 32'(m0_rvalid), 32'd0);
      idle();
      check("rst_rdata_zero", 32'(m0_rdata), 32'd0);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 39) != 0,
              1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dmem_arbiter
